regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32×32 register file. It shares the register file's single write port between the ALU and LSU result paths using a valid/ready handshake. It also tracks which destination registers have an outstanding write so that issue logic can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file's write port.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_valid / lsu_valid  in  1  requester has a result to write
- alu_ready / lsu_ready  out  1  grant; handshake when valid&&ready
- alu_rd / lsu_rd  in  ADDR_W  destination register
- alu_data / lsu_data  in  DATA_W  result data
- issue_set  in  1  instruction issued this cycle, marks issue_rd pending
- issue_rd, issue_rs1, issue_rs2  in  ADDR_W  issuing instruction's registers
- hazard  out  1  any of rs1/rs2/rd pending (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  ADDR_W  register-file write index (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)

## Operation
- Scoreboard: busy[2**ADDR_W-1:0]. busy[0] is hard-wired to 0.
- Setting a busy bit: issue_set with issue_rd≠0 sets busy[issue_rd].
- Clearing a busy bit: busy[rf_rd] clears at the edge where rf_we=1, which is the same edge the register file commits.
- hazard = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]. It is evaluated every cycle, independent of issue_set.
- Same-register set and clear on one edge: set wins.
- Arbitration is round-robin. Pointer `last` holds the most recently granted requester.
  - Both requesters valid: grant the one that is not `last`.
  - One requester valid: grant it.
  - `last` updates only on a handshake.
- At most one ready is high per cycle. ready is asserted only while the matching valid is high.
- On a handshake the next edge loads rf_rd/rf_wdata from the winner. rf_we = 1 only if that rd≠0.
  - A handshake with rd=0 is accepted and dropped. No write and no scoreboard change occur.
- A cycle with no handshake leaves rf_we=0 on the next edge. rf_rd/rf_wdata hold their values.
- Requesters must hold rd/data stable while valid&&!ready.

## Timing
- Reset values: busy all 0; rf_we=0, rf_rd=0, rf_wdata=0; last=LSU, so the ALU wins the first tie.
- Reset asserted mid-operation discards any in-flight write and clears the scoreboard immediately.
- ready is combinational from valid and `last`: zero-cycle grant.
- Handshake at edge N → rf_we high during cycle N+1 → register file written and busy cleared at edge N+2.
- hazard falls in cycle N+2, when the register file already holds the data.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate every cycle.

## Configuration
- RF_ARB_FIXED_PRIO_EN defined: LSU always wins when both requesters are valid, and `last` is unused. A continuously valid LSU starves the ALU; this is accepted by design.
- Undefined (default): round-robin as described above.

## Structure
- Shared package: DATA_W/ADDR_W defaults, requester-ID enum (REQ_ALU=0, REQ_LSU=1), and the register-count constant.
- One sub-module, rf_scoreboard, holds the busy vector with its set/clear logic and the hazard lookup. Arbitration and the output register stay in the top module.

## Test plan
- Reset → rf_we=0, hazard=0 for all indices. alu_valid=1 with rd=5, data=0xA5 → alu_ready=1 same cycle; rf_we=1, rf_rd=5, rf_wdata=0xA5 next cycle.
- issue_set, rd=7 → hazard=1 with issue_rs1=7. LSU writes rd=7 → hazard stays 1 through cycle N+1 and falls in cycle N+2.
- Both valid for 4 cycles (ALU rd=1, LSU rd=2) → grants ALU, LSU, ALU, LSU (round-robin). With RF_ARB_FIXED_PRIO_EN → LSU granted all 4 cycles.
- Handshake with rd=0, data=0xFFFF_FFFF → rf_we stays 0. An issue_set with rd=0 never produces hazard.
- busy[3] set and writing; issue_set rd=3 lands on the clear edge → busy[3] remains 1.
- Assert reset while busy[9]=1 and a handshake is in flight → busy cleared and rf_we=0 immediately, with no write to 9.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Optional feature macro: RF_ARB_FIXED_PRIO_EN (fixed LSU priority instead of round-robin).
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << DEF_ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready write-back request bundle for the ALU and LSU result paths.
// The slave modport faces the arbiter; the master modport faces the requesters.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::DEF_ADDR_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus
// the combinational RAW/WAW hazard lookup for the issuing instruction.
module rf_scoreboard #(
    parameter int ADDR_W = regfile_wb_arbiter_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic              hazard
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Next busy vector: set has priority over a same-index clear; x0 never busy
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            busy_nxt_s[i] = (set_en && (set_idx == ADDR_W'(i))) |
                            (busy_r[i] & ~(clr_en && (clr_idx == ADDR_W'(i))));
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Hazard lookup, evaluated every cycle regardless of issue_set
    always_comb begin
        hazard = busy_r[rs1] | busy_r[rs2] | busy_r[rd];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register-file write port between ALU and LSU.
// Define RF_ARB_FIXED_PRIO_EN for fixed LSU priority; default is round-robin.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 issue_set,
    input  logic [ADDR_W-1:0]    issue_rd,
    input  logic [ADDR_W-1:0]    issue_rs1,
    input  logic [ADDR_W-1:0]    issue_rs2,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_rd,
    output logic [DATA_W-1:0]    rf_wdata
);

    logic              alu_grant_s;
    logic              lsu_grant_s;
    logic              hs_s;
    logic [ADDR_W-1:0] win_rd_s;
    logic [DATA_W-1:0] win_data_s;
    logic              issue_mark_s;

    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_rd_r;
    logic [DATA_W-1:0] rf_wdata_r;

`ifdef RF_ARB_FIXED_PRIO_EN
    // Fixed priority grant: LSU always wins a tie
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (wb.lsu_valid) begin
            lsu_grant_s = 1'b1;
        end else if (wb.alu_valid) begin
            alu_grant_s = 1'b1;
        end else begin
            lsu_grant_s = 1'b0;
        end
    end
`else
    req_id_e last_r;

    // Round-robin grant: on a tie the requester that was not granted last wins
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (wb.alu_valid && wb.lsu_valid) begin
            case (last_r)
                REQ_ALU: lsu_grant_s = 1'b1;
                REQ_LSU: alu_grant_s = 1'b1;
                default: alu_grant_s = 1'b1;
            endcase
        end else if (wb.alu_valid) begin
            alu_grant_s = 1'b1;
        end else if (wb.lsu_valid) begin
            lsu_grant_s = 1'b1;
        end else begin
            alu_grant_s = 1'b0;
        end
    end

    // Most recently granted requester; resets to LSU so the ALU wins first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= REQ_LSU;
        end else if (alu_grant_s) begin
            last_r <= REQ_ALU;
        end else if (lsu_grant_s) begin
            last_r <= REQ_LSU;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Winner selection feeding the write-port register
    always_comb begin
        hs_s = alu_grant_s | lsu_grant_s;
        if (alu_grant_s) begin
            win_rd_s   = wb.alu_rd;
            win_data_s = wb.alu_data;
        end else begin
            win_rd_s   = wb.lsu_rd;
            win_data_s = wb.lsu_data;
        end
    end

    // Registered write port; rd=0 handshakes are accepted but never write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
        end else if (hs_s) begin
            rf_we_r    <= (win_rd_s != {ADDR_W{1'b0}});
            rf_rd_r    <= win_rd_s;
            rf_wdata_r <= win_data_s;
        end else begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= rf_rd_r;
            rf_wdata_r <= rf_wdata_r;
        end
    end

    // Output drives and the issue-side mark request
    always_comb begin
        wb.alu_ready = alu_grant_s;
        wb.lsu_ready = lsu_grant_s;
        rf_we        = rf_we_r;
        rf_rd        = rf_rd_r;
        rf_wdata     = rf_wdata_r;
        issue_mark_s = issue_set && (issue_rd != {ADDR_W{1'b0}});
    end

    // Busy bits clear on the same edge the register file commits rf_rd
    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (issue_mark_s),
        .set_idx (issue_rd),
        .clr_en  (rf_we_r),
        .clr_idx (rf_rd_r),
        .rs1     (issue_rs1),
        .rs2     (issue_rs2),
        .rd      (issue_rd),
        .hazard  (hazard)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; inputs change and
// outputs are sampled around the falling edge, away from the active edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        issue_set;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int checks;
    int errors;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wb ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (wb),
        .issue_set (issue_set),
        .issue_rd  (issue_rd),
        .issue_rs1 (issue_rs1),
        .issue_rs2 (issue_rs2),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wb.alu_valid = 1'b0; wb.alu_rd = 5'd0; wb.alu_data = 32'h0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = 5'd0; wb.lsu_data = 32'h0;
        issue_set = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b rd=%0d wdata=%h, want 0/0/0", rf_we, rf_rd, rf_wdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            issue_rs1 = 5'(i); issue_rs2 = 5'(i); issue_rd = 5'(i);
            #1;
            checks++;
            if (hazard !== 1'b0) begin
                errors++;
                $display("FAIL reset_hazard[%0d]: got %b want 0", i, hazard);
            end
        end
        idle_inputs();
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h0000_00A5;
        #1;
        checks++;
        if (wb.alu_ready !== 1'b1 || wb.lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_grant: got alu_ready=%b lsu_ready=%b want 1/0", wb.alu_ready, wb.lsu_ready);
        end
        @(negedge clk);
        wb.alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL alu_write: got we=%b rd=%0d wdata=%h want 1/5/a5", rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL idle_hold: got we=%b rd=%0d wdata=%h want 0/5/a5", rf_we, rf_rd, rf_wdata);
        end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        issue_set = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        issue_set = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd7;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h0000_0077;
        #1;
        checks++;
        if (hazard !== 1'b1 || wb.lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_set: got hazard=%b lsu_ready=%b want 1/1", hazard, wb.lsu_ready);
        end
        @(negedge clk);
        wb.lsu_valid = 1'b0;
        checks++;
        if (hazard !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd7) begin
            errors++;
            $display("FAIL hazard_n1: got hazard=%b we=%b rd=%0d want 1/1/7", hazard, rf_we, rf_rd);
        end
        @(negedge clk);
        checks++;
        if (hazard !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL hazard_n2: got hazard=%b we=%b want 0/0", hazard, rf_we);
        end
        issue_rs1 = 5'd0;
    endtask

    task automatic test_round_robin();
        logic exp_alu;
        @(negedge clk);
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd1; wb.alu_data = 32'h0000_0011;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd2; wb.lsu_data = 32'h0000_0022;
        for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            exp_alu = 1'b0;
`else
            exp_alu = (k % 2 == 0);
`endif
            #1;
            checks++;
            if (wb.alu_ready !== exp_alu || wb.lsu_ready !== !exp_alu) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got alu=%b lsu=%b want alu=%b lsu=%b", k, wb.alu_ready, wb.lsu_ready, exp_alu, !exp_alu);
            end
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== (exp_alu ? 5'd1 : 5'd2) || rf_wdata !== (exp_alu ? 32'h11 : 32'h22)) begin
                errors++;
                $display("FAIL rr_write[%0d]: got we=%b rd=%0d wdata=%h", k, rf_we, rf_rd, rf_wdata);
            end
        end
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (wb.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_accept: got alu_ready=%b want 1", wb.alu_ready);
        end
        @(negedge clk);
        wb.alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rd0_drop: got we=%b rd=%0d wdata=%h want 0/0/ffffffff", rf_we, rf_rd, rf_wdata);
        end
        issue_set = 1'b1; issue_rd = 5'd0;
        @(negedge clk);
        issue_set = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL rd0_issue: got hazard=%b want 0", hazard);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        issue_set = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_set = 1'b0; issue_rd = 5'd0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h0000_0033;
        @(negedge clk);
        wb.alu_valid = 1'b0;
        issue_set = 1'b1; issue_rd = 5'd3;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin
            errors++;
            $display("FAIL setwin_write: got we=%b rd=%0d want 1/3", rf_we, rf_rd);
        end
        @(negedge clk);
        issue_set = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd3;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL setwin_busy: got hazard=%b want 1", hazard);
        end
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd3; wb.lsu_data = 32'h0000_0333;
        @(negedge clk);
        wb.lsu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL setwin_clear: got hazard=%b want 0", hazard);
        end
        issue_rs1 = 5'd0;
    endtask

    task automatic test_reset_midop();
        logic exp_alu;
        @(negedge clk);
        issue_set = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_set = 1'b0; issue_rd = 5'd0; issue_rs2 = 5'd9;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 32'h0000_0099;
        @(negedge clk);
        wb.lsu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: got we=%b hazard=%b want 1/1", rf_we, hazard);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || hazard !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset: got we=%b hazard=%b rd=%0d wdata=%h want 0/0/0/0", rf_we, hazard, rf_rd, rf_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        issue_rs2 = 5'd0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd4; wb.alu_data = 32'h0000_0044;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd6; wb.lsu_data = 32'h0000_0066;
`ifdef RF_ARB_FIXED_PRIO_EN
        exp_alu = 1'b0;
`else
        exp_alu = 1'b1;
`endif
        #1;
        checks++;
        if (wb.alu_ready !== exp_alu || wb.lsu_ready !== !exp_alu || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: got alu=%b lsu=%b we=%b want alu=%b we=0", wb.alu_ready, wb.lsu_ready, rf_we, exp_alu);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_write();
        test_hazard();
        test_round_robin();
        test_rd_zero();
        test_set_wins();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
